read_addr_channel_arbiter: RTL and testbench

- Read address (AR) channel arbiter that sits directly upstream of the read address decoder.
- Accepts AR requests from Num_OF_Masters masters and grants one at a time using round-robin.
- Drives the granted master's AR fields onto the single selected-master bus, together with the master index on Master_AXI_araddr_ID.
- Returns the decoder's Sel_Slave_Ready to the granted master only.

---
 rtl/read_addr_channel_arbiter.sv | 151 +++++++++++++++
 tb/tb_read_addr_channel_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/read_addr_channel_arbiter.sv
// Round-robin arbiter for the AXI read-address channel. It is placed in front of the read address decoder.
// Define READ_ARB_QOS_EN to make the highest ARQOS win. Ties then fall back to round-robin order.
module read_addr_channel_arbiter #(
  parameter int Num_OF_Masters  = 2,
  parameter int Masters_ID_Size = $clog2(Num_OF_Masters),
  parameter int Address_width   = 32,
  parameter int AXI4_AR_len     = 8
) (
  input  logic                                   ACLK,
  input  logic                                   ARESET,
  input  logic [Num_OF_Masters*Address_width-1:0] S_AXI_araddr,
  input  logic [Num_OF_Masters*AXI4_AR_len-1:0]   S_AXI_arlen,
  input  logic [Num_OF_Masters*3-1:0]             S_AXI_arsize,
  input  logic [Num_OF_Masters*2-1:0]             S_AXI_arburst,
  input  logic [Num_OF_Masters*2-1:0]             S_AXI_arlock,
  input  logic [Num_OF_Masters*4-1:0]             S_AXI_arcache,
  input  logic [Num_OF_Masters*3-1:0]             S_AXI_arprot,
  input  logic [Num_OF_Masters*4-1:0]             S_AXI_arqos,
  input  logic [Num_OF_Masters*4-1:0]             S_AXI_arregion,
  input  logic [Num_OF_Masters-1:0]               S_AXI_arvalid,
  output logic [Num_OF_Masters-1:0]               S_AXI_arready,
  output logic [Masters_ID_Size-1:0]              Master_AXI_araddr_ID,
  output logic [Address_width-1:0]                Master_AXI_araddr,
  output logic [AXI4_AR_len-1:0]                  Master_AXI_arlen,
  output logic [2:0]                              Master_AXI_arsize,
  output logic [1:0]                              Master_AXI_arburst,
  output logic [1:0]                              Master_AXI_arlock,
  output logic [3:0]                              Master_AXI_arcache,
  output logic [2:0]                              Master_AXI_arprot,
  output logic [3:0]                              Master_AXI_arqos,
  output logic [3:0]                              Master_AXI_arregion,
  output logic                                    Master_AXI_arvalid,
  input  logic                                    Sel_Slave_Ready
);

  typedef enum logic {IDLE = 1'b0, GRANTED = 1'b1} state_t;

  state_t                     state_q, state_d;
  logic [Masters_ID_Size-1:0] grant_idx_q, grant_idx_d;
  logic [Masters_ID_Size-1:0] last_grant_q, last_grant_d;
  logic [Masters_ID_Size-1:0] pick_idx;
  logic [Masters_ID_Size-1:0] slot;
  logic                       pick_found;
  logic                       gnt_valid;
`ifdef READ_ARB_QOS_EN
  logic [3:0]                 best_qos;
  logic [3:0]                 slot_qos;
`endif

  // k-th master in round-robin order after the last granted master.
  function automatic logic [Masters_ID_Size-1:0] rr_slot(
    input logic [Masters_ID_Size-1:0] last,
    input int                         k
  );
    return Masters_ID_Size'((int'(last) + k) % Num_OF_Masters);
  endfunction

  // Candidates are checked in rotating order. The last candidate checked gets the lowest priority.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    slot       = '0;
`ifdef READ_ARB_QOS_EN
    best_qos   = '0;
    slot_qos   = '0;
`endif
    for (int k = 1; k <= Num_OF_Masters; k++) begin
      slot = rr_slot(last_grant_q, k);
`ifdef READ_ARB_QOS_EN
      slot_qos = S_AXI_arqos[int'(slot)*4 +: 4];
      if (S_AXI_arvalid[slot] && (!pick_found || (slot_qos > best_qos))) begin
        pick_found = 1'b1;
        pick_idx   = slot;
        best_qos   = slot_qos;
      end
`else
      if (S_AXI_arvalid[slot] && !pick_found) begin
        pick_found = 1'b1;
        pick_idx   = slot;
      end
`endif
    end
  end

  assign gnt_valid = S_AXI_arvalid[grant_idx_q];

  always_comb begin
    state_d      = state_q;
    grant_idx_d  = grant_idx_q;
    last_grant_d = last_grant_q;
    if (state_q == IDLE) begin
      if (pick_found) begin
        grant_idx_d = pick_idx;
        state_d     = GRANTED;
      end
    end else begin
      // If the master withdraws its request early, drop it without taking a round-robin turn.
      if (!gnt_valid) begin
        state_d = IDLE;
      end else if (Sel_Slave_Ready) begin
        last_grant_d = grant_idx_q;
        state_d      = IDLE;
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q      <= IDLE;
      grant_idx_q  <= '0;
      last_grant_q <= Masters_ID_Size'(Num_OF_Masters - 1);
    end else begin
      state_q      <= state_d;
      grant_idx_q  <= grant_idx_d;
      last_grant_q <= last_grant_d;
    end
  end

  // The output mux is driven only by registered state. No ARVALID reaches ARREADY combinationally.
  always_comb begin
    Master_AXI_araddr_ID = '0;
    Master_AXI_araddr    = '0;
    Master_AXI_arlen     = '0;
    Master_AXI_arsize    = '0;
    Master_AXI_arburst   = '0;
    Master_AXI_arlock    = '0;
    Master_AXI_arcache   = '0;
    Master_AXI_arprot    = '0;
    Master_AXI_arqos     = '0;
    Master_AXI_arregion  = '0;
    Master_AXI_arvalid   = 1'b0;
    S_AXI_arready        = '0;
    for (int i = 0; i < Num_OF_Masters; i++) begin
      if ((state_q == GRANTED) && (grant_idx_q == Masters_ID_Size'(i))) begin
        Master_AXI_araddr_ID = grant_idx_q;
        Master_AXI_araddr    = S_AXI_araddr[i*Address_width +: Address_width];
        Master_AXI_arlen     = S_AXI_arlen[i*AXI4_AR_len +: AXI4_AR_len];
        Master_AXI_arsize    = S_AXI_arsize[i*3 +: 3];
        Master_AXI_arburst   = S_AXI_arburst[i*2 +: 2];
        Master_AXI_arlock    = S_AXI_arlock[i*2 +: 2];
        Master_AXI_arcache   = S_AXI_arcache[i*4 +: 4];
        Master_AXI_arprot    = S_AXI_arprot[i*3 +: 3];
        Master_AXI_arqos     = S_AXI_arqos[i*4 +: 4];
        Master_AXI_arregion  = S_AXI_arregion[i*4 +: 4];
        Master_AXI_arvalid   = S_AXI_arvalid[i];
        S_AXI_arready[i]     = Sel_Slave_Ready;
      end
    end
  end

endmodule

// File: tb/tb_read_addr_channel_arbiter.sv
// Directed testbench for read_addr_channel_arbiter with two masters.
// A transaction-level model is checked against the DUT every cycle, alongside fixed literal expectations.
module tb_read_addr_channel_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int LW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N*AW-1:0] s_araddr  = '0;
  logic [N*LW-1:0] s_arlen   = '0;
  logic [N*3-1:0]  s_arsize  = '0;
  logic [N*2-1:0]  s_arburst = '0;
  logic [N*2-1:0]  s_arlock  = '0;
  logic [N*4-1:0]  s_arcache = '0;
  logic [N*3-1:0]  s_arprot  = '0;
  logic [N*4-1:0]  s_arqos   = '0;
  logic [N*4-1:0]  s_arregion = '0;
  logic [N-1:0]    s_arvalid = '0;
  logic [N-1:0]    s_arready;
  logic            ready = 1'b0;
  logic [0:0]      m_id;
  logic [AW-1:0]   m_araddr;
  logic [LW-1:0]   m_arlen;
  logic [2:0]      m_arsize;
  logic [1:0]      m_arburst, m_arlock;
  logic [3:0]      m_arcache, m_arqos, m_arregion;
  logic [2:0]      m_arprot;
  logic            m_arvalid;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int log_id[$];
  int log_cyc[$];

  // Model state: whether a grant is outstanding, its owner, and the last owner that completed a handshake.
  bit md_g    = 1'b0;
  int md_i    = 0;
  int md_last = N - 1;

  read_addr_channel_arbiter #(.Num_OF_Masters(N), .Address_width(AW), .AXI4_AR_len(LW)) dut (
    .ACLK(clk), .ARESET(rst),
    .S_AXI_araddr(s_araddr), .S_AXI_arlen(s_arlen), .S_AXI_arsize(s_arsize),
    .S_AXI_arburst(s_arburst), .S_AXI_arlock(s_arlock), .S_AXI_arcache(s_arcache),
    .S_AXI_arprot(s_arprot), .S_AXI_arqos(s_arqos), .S_AXI_arregion(s_arregion),
    .S_AXI_arvalid(s_arvalid), .S_AXI_arready(s_arready),
    .Master_AXI_araddr_ID(m_id), .Master_AXI_araddr(m_araddr), .Master_AXI_arlen(m_arlen),
    .Master_AXI_arsize(m_arsize), .Master_AXI_arburst(m_arburst), .Master_AXI_arlock(m_arlock),
    .Master_AXI_arcache(m_arcache), .Master_AXI_arprot(m_arprot), .Master_AXI_arqos(m_arqos),
    .Master_AXI_arregion(m_arregion), .Master_AXI_arvalid(m_arvalid),
    .Sel_Slave_Ready(ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Choose the requester that wins arbitration. Start at last+1 and wrap around.
  // With QoS enabled, only a strictly higher ARQOS can displace an earlier candidate.
  function automatic int pick(input logic [N-1:0] v, input logic [N*4-1:0] q, input int last);
    int best = -1;
    for (int k = 1; k <= N; k++) begin
      int c = (last + k) % N;
      if (v[c]) begin
`ifdef READ_ARB_QOS_EN
        if (best < 0 || q[c*4 +: 4] > q[best*4 +: 4]) best = c;
`else
        if (best < 0) best = c;
`endif
      end
    end
    return best;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      md_g <= 1'b0; md_i <= 0; md_last <= N - 1;
    end else if (!md_g) begin
      if (pick(s_arvalid, s_arqos, md_last) >= 0) begin
        md_g <= 1'b1;
        md_i <= pick(s_arvalid, s_arqos, md_last);
      end
    end else if (!s_arvalid[md_i]) begin
      md_g <= 1'b0;
    end else if (ready) begin
      md_last <= md_i;
      md_g    <= 1'b0;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [63:0] ef, ec;
    ef = '0;
    ec = '0;
    if (md_g) begin
      ef = {2'b0, s_araddr[md_i*AW +: AW], s_arlen[md_i*LW +: LW], s_arsize[md_i*3 +: 3],
            s_arburst[md_i*2 +: 2], s_arlock[md_i*2 +: 2], s_arcache[md_i*4 +: 4],
            s_arprot[md_i*3 +: 3], s_arqos[md_i*4 +: 4], s_arregion[md_i*4 +: 4]};
      ec = {60'b0, s_arvalid[md_i], (ready ? 2'(1 << md_i) : 2'b00), 1'(md_i)};
    end
    chk("model_fields", {2'b0, m_araddr, m_arlen, m_arsize, m_arburst, m_arlock, m_arcache,
                         m_arprot, m_arqos, m_arregion}, ef);
    chk("model_ctrl", {60'b0, m_arvalid, s_arready, m_id}, ec);
    if (m_arvalid && ready && !rst) begin
      log_id.push_back(int'(m_id));
      log_cyc.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_m(input int i, input logic v, input logic [31:0] a, input logic [7:0] l,
                       input logic [3:0] q);
    s_arvalid[i]          = v;
    s_araddr[i*AW +: AW]  = a;
    s_arlen[i*LW +: LW]   = l;
    s_arqos[i*4 +: 4]     = q;
    s_arsize[i*3 +: 3]    = 3'(i + 2);
    s_arburst[i*2 +: 2]   = 2'(i + 1);
    s_arlock[i*2 +: 2]    = 2'(i + 1);
    s_arcache[i*4 +: 4]   = 4'(i + 6);
    s_arprot[i*3 +: 3]    = 3'(i + 3);
    s_arregion[i*4 +: 4]  = 4'(i + 10);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_arvalid = '0;
    ready = 1'b0;
    #1;
    chk("reset_arvalid", 64'(m_arvalid), 64'd0);
    chk("reset_arready", 64'(s_arready), 64'd0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    // Single transfer from master 0.
    do_reset();
    chk("reset_addr_id", {31'b0, m_id, m_araddr}, 64'd0);
    set_m(0, 1'b1, 32'h4000_0010, 8'd3, 4'd0);
    set_m(1, 1'b0, 32'h8000_0200, 8'd7, 4'd0);
    ready = 1'b1;
    #1 chk("t1_latency_idle", 64'(m_arvalid), 64'd0);
    step();
    #1 chk("t1_arvalid", 64'(m_arvalid), 64'd1);
    chk("t1_id", 64'(m_id), 64'd0);
    chk("t1_addr", 64'(m_araddr), 64'h4000_0010);
    chk("t1_len", 64'(m_arlen), 64'd3);
    chk("t1_arready", 64'(s_arready), 64'b01);
    step();
    s_arvalid = '0;
    #1 chk("t1_back_idle", 64'({m_arvalid, s_arready}), 64'd0);

    // Both masters request continuously.
    do_reset();
    set_m(0, 1'b1, 32'h1000_0000, 8'd1, 4'd0);
    set_m(1, 1'b1, 32'h2000_0000, 8'd2, 4'd0);
    ready = 1'b1;
    log_id.delete();
    log_cyc.delete();
    repeat (9) step();
    s_arvalid = '0;
    chk("t2_count_ge4", 64'(log_id.size() >= 4), 64'd1);
    if (log_id.size() >= 4) begin
      chk("t2_id0", 64'(log_id[0]), 64'd0);
      chk("t2_id1", 64'(log_id[1]), 64'd1);
      chk("t2_id2", 64'(log_id[2]), 64'd0);
      chk("t2_id3", 64'(log_id[3]), 64'd1);
      chk("t2_spacing", 64'(log_cyc[3] - log_cyc[2]), 64'd2);
    end

    // While the slave is stalled, the grant stays with master 1.
    do_reset();
    set_m(1, 1'b1, 32'hABCD_0040, 8'd15, 4'd0);
    step();
    set_m(0, 1'b1, 32'h1111_2220, 8'd4, 4'd0);
    #1 chk("t3_id", 64'(m_id), 64'd1);
    for (int c = 0; c < 5; c++) begin
      step();
      #1 chk("t3_hold_addr", 64'({m_id, m_araddr}), {31'b0, 1'b1, 32'hABCD_0040});
      chk("t3_hold_ready", 64'(s_arready), 64'd0);
    end
    ready = 1'b1;
    #1 chk("t3_ready_m1", 64'(s_arready), 64'b10);
    step();
    #1 chk("t3_idle", 64'(m_arvalid), 64'd0);
    step();
    #1 chk("t3_next_m0", 64'({m_arvalid, m_id}), 64'b10);
    s_arvalid = '0;

    // Reset asserted while a grant is active.
    do_reset();
    set_m(1, 1'b1, 32'h3000_0008, 8'd0, 4'd0);
    ready = 1'b1;
    step();
    step();
    ready = 1'b0;
    step();
    #1 chk("t4_granted", 64'({m_arvalid, m_id}), 64'b11);
    ready = 1'b1;
    #1 rst = 1'b1;
    #1 chk("t4_async_clear", 64'({m_arvalid, s_arready}), 64'd0);
    set_m(0, 1'b1, 32'h0000_0100, 8'd2, 4'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    step();
    #1 chk("t4_m0_first", 64'({m_arvalid, m_id}), 64'b10);
    s_arvalid = '0;

    // Master 0 withdraws its request before the handshake.
    do_reset();
    set_m(0, 1'b1, 32'h5000_0000, 8'd9, 4'd0);
    step();
    #1 chk("t5_granted0", 64'({m_arvalid, m_id}), 64'b10);
    s_arvalid = 2'b10;
    #1 chk("t5_drop_comb", 64'(m_arvalid), 64'd0);
    step();
    s_arvalid = 2'b11;
    #1 chk("t5_idle", 64'(m_arvalid), 64'd0);
    step();
    #1 chk("t5_m0_again", 64'({m_arvalid, m_id}), 64'b10);
    s_arvalid = '0;

`ifdef READ_ARB_QOS_EN
    // QoS priority, then equal QoS falling back to round-robin.
    do_reset();
    set_m(0, 1'b1, 32'h6000_0000, 8'd1, 4'd2);
    set_m(1, 1'b1, 32'h7000_0000, 8'd1, 4'd9);
    step();
    #1 chk("q_high_wins", 64'(m_id), 64'd1);
    do_reset();
    set_m(0, 1'b1, 32'h6000_0000, 8'd1, 4'd5);
    set_m(1, 1'b1, 32'h7000_0000, 8'd1, 4'd5);
    ready = 1'b1;
    log_id.delete();
    repeat (6) step();
    s_arvalid = '0;
    chk("q_count_ge3", 64'(log_id.size() >= 3), 64'd1);
    if (log_id.size() >= 3) begin
      chk("q_rr0", 64'(log_id[0]), 64'd0);
      chk("q_rr1", 64'(log_id[1]), 64'd1);
      chk("q_rr2", 64'(log_id[2]), 64'd0);
    end
`endif

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
